// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with almost flags, occupancy, sticky errors and standard/FWFT read modes
module sync_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int AF_THRESH  = 1020,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] AF = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE = (ADDR_WIDTH+1)'(AE_THRESH);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  we, re;
  assign we = wen && !full;
  assign re = ren && !empty;
  assign count_nxt = (we && !re) ? count + 1'b1 : (re && !we) ? count - 1'b1 : count;
  // storage write; reset blocks the write but does not clear contents
  always_ff @(posedge clk)
    if (!rst && we) mem[wr_ptr] <= wdata;
  // pointers, occupancy and flags, all registered from the next occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      count        <= count_nxt;
      full         <= count_nxt[ADDR_WIDTH];
      empty        <= count_nxt == '0;
      almost_full  <= count_nxt >= AF;
      almost_empty <= count_nxt <= AE;
    end
  end
  // sticky errors; a new error wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wen && full) ? 1'b1 : err_clr ? 1'b0 : overflow;
      underflow <= (ren && empty) ? 1'b1 : err_clr ? 1'b0 : underflow;
    end
  end
  if (FWFT != 0) begin : g_fwft
    assign rdata  = empty ? '0 : mem[rd_ptr];
    assign rvalid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;
    // registered read: data captured on an accepted read, valid for one cycle
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= re;
        if (re) rdata_q <= mem[rd_ptr];
      end
    end
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench driving a standard and an FWFT instance in lockstep
module tb_sync_fifo_param;
  logic clk = 0, rst = 1, wen = 0, ren = 0, err_clr = 0;
  logic [7:0] wdata = 0;
  logic [7:0] rdata0, rdata1;
  logic [4:0] count0, count1;
  logic rvalid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic rvalid1, full1, empty1, af1, ae1, ovf1, unf1;
  int n_chk = 0, n_fail = 0;
  logic [7:0] q[$], sb[$];
  logic [7:0] last_rd = 0;
  logic ovf_m = 0, unf_m = 0;

  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren), .err_clr(err_clr),
    .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren), .err_clr(err_clr),
    .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r_, input logic w, input logic [7:0] d, input logic r, input logic c);
    int n;
    bit aw, ar;
    rst = r_; wen = w; wdata = d; ren = r; err_clr = c;
    n = q.size();
    aw = w && n != 16;
    ar = r && n != 0;
    @(posedge clk);
    if (r_) begin
      q.delete(); sb.delete();
      last_rd = 0; ovf_m = 0; unf_m = 0; ar = 0;
    end else begin
      ovf_m = (w && n == 16) ? 1'b1 : c ? 1'b0 : ovf_m;
      unf_m = (r && n == 0) ? 1'b1 : c ? 1'b0 : unf_m;
      if (ar) sb.push_back(q.pop_front());
      if (aw) q.push_back(d);
    end
    #1;
    n = q.size();
    chk("count0", count0, n);
    chk("count1", count1, n);
    chk("full0", full0, n == 16);
    chk("full1", full1, n == 16);
    chk("empty0", empty0, n == 0);
    chk("empty1", empty1, n == 0);
    chk("almost_full0", af0, n >= 14);
    chk("almost_full1", af1, n >= 14);
    chk("almost_empty0", ae0, n <= 2);
    chk("almost_empty1", ae1, n <= 2);
    chk("overflow0", ovf0, ovf_m);
    chk("overflow1", ovf1, ovf_m);
    chk("underflow0", unf0, unf_m);
    chk("underflow1", unf1, unf_m);
    chk("rvalid0", rvalid0, ar);
    if (rvalid0 && sb.size() != 0) last_rd = sb.pop_front();
    chk("rdata0", rdata0, last_rd);
    chk("rvalid1", rvalid1, n != 0);
    chk("rdata1", rdata1, n != 0 ? q[0] : 8'h00);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'(i), 0, 0);
    cyc(0, 1, 8'hAA, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 8'hAB, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h10 + 8'(i), 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 1, 8'h20 + 8'(i), 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 8'h77, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 8'h5C, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'h60 + 8'(i), 0, 0);
    cyc(0, 1, 8'h99, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
